// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a length-prefixed, XOR-checksummed program image byte by byte
// and writes it word by word into instruction memory starting at BASE_ADDR.
module uart_boot_loader #(
  parameter int unsigned            ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR      = '0,
  parameter int unsigned            MAX_WORDS      = 1024,
  parameter int unsigned            TIMEOUT_CYCLES = 117200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [9:0]            rx_frame,
  input  logic                  rx_status,
  output logic                  rx_read_enable,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            err_code
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    StIdle, StLen, StData, StWrite, StCsum, StDone, StError
  } state_e;

  state_e                r_state, w_state_next;
  logic                  r_rx_status_q;
  logic [31:0]           r_len, w_len_next;
  logic [31:0]           r_word, w_word_next;
  logic [31:0]           r_word_cnt, w_word_cnt_next;
  logic [1:0]            r_byte_cnt, w_byte_cnt_next;
  logic [7:0]            r_csum, w_csum_next;
  logic [TW-1:0]         r_timer, w_timer_next;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_next;
  logic [31:0]           r_mem_wdata, w_mem_wdata_next;
  logic [2:0]            r_err_code, w_err_code_next;

  logic                  w_rx_active;
  logic                  w_accept;
  logic                  w_frame_bad;
  logic [7:0]            w_byte;
  logic [31:0]           w_len_shift;
  logic [31:0]           w_word_shift;

  assign w_rx_active  = (r_state == StLen) || (r_state == StData) || (r_state == StCsum);
  assign w_accept     = w_rx_active && rx_status && !r_rx_status_q;
  assign w_byte       = rx_frame[8:1];
  assign w_frame_bad  = rx_frame[0] || !rx_frame[9];
  // Little-endian assembly: each new byte enters at the top and moves down.
  assign w_len_shift  = {w_byte, r_len[31:8]};
  assign w_word_shift = {w_byte, r_word[31:8]};

  always_comb begin
    w_state_next     = r_state;
    w_len_next       = r_len;
    w_word_next      = r_word;
    w_word_cnt_next  = r_word_cnt;
    w_byte_cnt_next  = r_byte_cnt;
    w_csum_next      = r_csum;
    w_timer_next     = r_timer;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_err_code_next  = r_err_code;

    unique case (r_state)
      StIdle, StDone, StError: begin
        if (start) begin
          w_state_next    = StLen;
          w_len_next      = '0;
          w_word_next     = '0;
          w_word_cnt_next = '0;
          w_byte_cnt_next = '0;
          w_csum_next     = '0;
          w_timer_next    = '0;
          w_err_code_next = 3'd0;
        end
      end
      StLen, StData, StCsum: begin
        if (w_accept) begin
          w_timer_next    = '0;
          w_byte_cnt_next = r_byte_cnt + 2'd1;
          if (w_frame_bad) begin
            w_state_next    = StError;
            w_err_code_next = 3'd1;
          end else if (r_state == StLen) begin
            w_len_next = w_len_shift;
            if (r_byte_cnt == 2'd3) begin
              if ((w_len_shift == 32'd0) || (w_len_shift > 32'(MAX_WORDS))) begin
                w_state_next    = StError;
                w_err_code_next = 3'd2;
              end else begin
                w_state_next = StData;
              end
            end
          end else if (r_state == StData) begin
            w_word_next = w_word_shift;
            w_csum_next = r_csum ^ w_byte;
            if (r_byte_cnt == 2'd3) begin
              w_state_next     = StWrite;
              w_mem_addr_next  = BASE_ADDR + ADDR_WIDTH'({r_word_cnt, 2'b00});
              w_mem_wdata_next = w_word_shift;
            end
          end else begin
            if (w_byte != r_csum) begin
              w_state_next    = StError;
              w_err_code_next = 3'd3;
            end else begin
              w_state_next = StDone;
            end
          end
        end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
          w_state_next    = StError;
          w_err_code_next = 3'd4;
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
      end
      StWrite: begin
        w_word_cnt_next = r_word_cnt + 32'd1;
        w_state_next    = ((r_word_cnt + 32'd1) == r_len) ? StCsum : StData;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_rx_status_q <= 1'b0;
      r_len         <= '0;
      r_word        <= '0;
      r_word_cnt    <= '0;
      r_byte_cnt    <= '0;
      r_csum        <= '0;
      r_timer       <= '0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_err_code    <= '0;
    end else begin
      r_state       <= w_state_next;
      r_rx_status_q <= rx_status;
      r_len         <= w_len_next;
      r_word        <= w_word_next;
      r_word_cnt    <= w_word_cnt_next;
      r_byte_cnt    <= w_byte_cnt_next;
      r_csum        <= w_csum_next;
      r_timer       <= w_timer_next;
      r_mem_addr    <= w_mem_addr_next;
      r_mem_wdata   <= w_mem_wdata_next;
      r_err_code    <= w_err_code_next;
    end
  end

  assign rx_read_enable = w_rx_active;
  assign busy           = w_rx_active || (r_state == StWrite);
  assign mem_we         = (r_state == StWrite);
  assign mem_addr       = r_mem_addr;
  assign mem_wdata      = r_mem_wdata;
  assign done           = (r_state == StDone);
  assign error          = (r_state == StError);
  assign err_code       = r_err_code;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: stimulus pushes expected writes and end-of-load status,
// a negedge monitor pops and compares whenever mem_we fires or busy falls.
module tb_uart_boot_loader;

  localparam int unsigned AW      = 32;
  localparam logic [31:0] BASE    = 32'h0000_0100;
  localparam int unsigned MAXW    = 4;
  localparam int unsigned TIMEOUT = 200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [9:0]    rx_frame = 10'h200;
  logic          rx_status = 1'b0;
  logic          rx_read_enable;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          error;
  logic [2:0]    err_code;

  uart_boot_loader #(
    .ADDR_WIDTH     (AW),
    .BASE_ADDR      (BASE),
    .MAX_WORDS      (MAXW),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .rx_frame       (rx_frame),
    .rx_status      (rx_status),
    .rx_read_enable (rx_read_enable),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .err_code       (err_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        wq[$];
  logic [4:0] sq[$];  // {done, error, err_code}

  int n_checks = 0;
  int n_pass   = 0;
  int g_hold   = 1;
  logic prev_busy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s", name);
  endtask

  // Monitor: compare against scoreboard whenever the DUT writes or finishes a load.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
    end else begin
      if (mem_we) begin
        if (wq.size() == 0) begin
          fail_now($sformatf("unexpected_write addr=%0h data=%0h", mem_addr, mem_wdata));
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_addr", 64'(mem_addr), 64'(w.addr));
          chk("wr_data", 64'(mem_wdata), 64'(w.data));
        end
      end
      if (prev_busy && !busy) begin
        if (sq.size() == 0) begin
          fail_now($sformatf("unexpected_end done=%0b error=%0b code=%0d", done, error, err_code));
        end else begin
          logic [4:0] s;
          s = sq.pop_front();
          chk("end_status", 64'({done, error, err_code}), 64'(s));
        end
      end
      prev_busy = busy;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx_frame  = {stop_bit, b, 1'b0};
    rx_status = 1'b1;
    repeat (g_hold) @(posedge clk);
    #1 rx_status = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 1000 && busy; i++) @(posedge clk);
    chk(name, 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'd0);
    chk({tag, "_code"}, 64'(err_code), 64'd0);
    chk({tag, "_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_rxen"}, 64'(rx_read_enable), 64'd0);
  endtask

  // Image {0x11223344, 0xAABBCCDD}: XOR of data bytes is 0x44.
  task automatic run_image(input logic [7:0] csum, input logic [4:0] status);
    do_start();
    chk("rxen_in_len", 64'(rx_read_enable), 64'd1);
    wq.push_back('{addr: BASE, data: 32'h1122_3344});
    wq.push_back('{addr: BASE + 32'd4, data: 32'hAABB_CCDD});
    sq.push_back(status);
    send_word(32'd2);
    send_word(32'h1122_3344);
    send_word(32'hAABB_CCDD);
    send_byte(csum, 1'b1);
    wait_idle("img_end");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("reset");

    // Good image, then bad checksums; both writes still land.
    run_image(8'h44, {1'b1, 1'b0, 3'd0});
    run_image(8'h5A, {1'b0, 1'b1, 3'd3});
    run_image(8'h00, {1'b0, 1'b1, 3'd3});

    // Framing error on second length byte.
    do_start();
    sq.push_back({1'b0, 1'b1, 3'd1});
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b0);
    wait_idle("frame_end");

    // Length zero and length MAXW+1.
    do_start();
    sq.push_back({1'b0, 1'b1, 3'd2});
    send_word(32'd0);
    wait_idle("len0_end");
    do_start();
    sq.push_back({1'b0, 1'b1, 3'd2});
    send_word(32'(MAXW + 1));
    wait_idle("lenmax_end");

    // Timeout after five data bytes; still busy shortly before the limit.
    do_start();
    wq.push_back('{addr: BASE, data: 32'h1122_3344});
    sq.push_back({1'b0, 1'b1, 3'd4});
    send_word(32'd2);
    send_word(32'h1122_3344);
    send_byte(8'hDD, 1'b1);
    repeat (TIMEOUT - 10) @(posedge clk);
    #1 chk("busy_before_timeout", 64'(busy), 64'd1);
    wait_idle("timeout_end");

    // Reset in the middle of DATA, then a fresh load restarts at BASE.
    do_start();
    send_word(32'd2);
    send_byte(8'h44, 1'b1);
    send_byte(8'h33, 1'b1);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_state("midreset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_image(8'h44, {1'b1, 1'b0, 3'd0});

    // Edge sent while DONE is dropped; 3-clk status pulses count once;
    // a start pulse mid-load is ignored.
    send_byte(8'h99, 1'b1);
    chk("done_kept", 64'(done), 64'd1);
    g_hold = 3;
    do_start();
    wq.push_back('{addr: BASE, data: 32'h1122_3344});
    wq.push_back('{addr: BASE + 32'd4, data: 32'hAABB_CCDD});
    sq.push_back({1'b1, 1'b0, 3'd0});
    send_word(32'd2);
    do_start();
    send_word(32'h1122_3344);
    send_word(32'hAABB_CCDD);
    send_byte(8'h44, 1'b1);
    wait_idle("hold_end");
    g_hold = 1;

    repeat (4) @(posedge clk);
    #1;
    chk("writes_left", 64'(wq.size()), 64'd0);
    chk("status_left", 64'(sq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
